// File: rtl/uart_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler_if
// Brief    : Stream bundle for the UART TX scheduler. It carries the NUM_SRC
//            byte-wide producer streams and the framed byte stream that goes
//            to the UART.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_scheduler_if #(
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC*8-1:0] src_tdata;
    logic [NUM_SRC-1:0]   src_tvalid;
    logic [NUM_SRC-1:0]   src_tlast;
    logic [NUM_SRC-1:0]   src_tready;
    logic [7:0]           m_tdata;
    logic                 m_tvalid;
    logic                 m_tlast;
    logic                 m_tready;

    // Scheduler side: it sinks the producer streams and masters the UART stream.
    modport master (
        input  src_tdata, src_tvalid, src_tlast, m_tready,
        output src_tready, m_tdata, m_tvalid, m_tlast
    );

    // Environment side: it holds the producers and the UART port.
    modport slave (
        output src_tdata, src_tvalid, src_tlast, m_tready,
        input  src_tready, m_tdata, m_tvalid, m_tlast
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Brief    : Round-robin scheduler that shares the UART TX byte stream
//            between NUM_SRC producers. It buffers up to MAX_BURST bytes from
//            the granted source. It then emits one record made of a header,
//            a length byte and the data bytes.
//            Optional macro UART_TX_SCHED_STATS_EN adds the rec_count and
//            byte_count statistics ports.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler #(
    parameter int         NUM_SRC      = 4,
    parameter int         MAX_BURST    = 16,
    parameter int         IDLE_TIMEOUT = 16,
    parameter logic [7:0] HDR_BASE     = 8'h08
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    uart_tx_scheduler_if.master bus,
    output logic                busy,
    output logic [2:0]          grant_idx
`ifdef UART_TX_SCHED_STATS_EN
    ,
    output logic [15:0]         rec_count,
    output logic [15:0]         byte_count
`endif
);

    localparam int c_CW    = $clog2(MAX_BURST + 1);
    localparam int c_AW    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int c_DEPTH = 1 << c_AW;
    localparam int c_TW    = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [c_CW-1:0] c_MAX      = c_CW'(MAX_BURST);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(IDLE_TIMEOUT - 1);
    localparam logic [c_TW-1:0] c_TMR_ONE  = c_TW'(1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_COLLECT = 3'd1;
    localparam logic [2:0] c_HDR     = 3'd2;
    localparam logic [2:0] c_LEN     = 3'd3;
    localparam logic [2:0] c_DATA    = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          r_rr_ptr;
    logic [2:0]          r_grant_idx;
    logic [c_CW-1:0]     r_cnt;
    logic [c_CW-1:0]     r_rd;
    logic [c_TW-1:0]     r_timer;
    logic                r_eop;
    logic [7:0]          r_buf [c_DEPTH];

    logic                w_hit;
    logic [2:0]          w_winner;
    logic [2:0]          w_rr_next;
    int                  w_best_d;
    logic [7:0]          w_sel_data;
    logic                w_sel_valid;
    logic                w_sel_last;
    logic [NUM_SRC-1:0]  w_tready;
    logic                w_accept;
    logic                w_rd_last;
    logic [6:0]          w_hdr_type;
    logic [7:0]          w_m_tdata;
    logic                w_m_tvalid;
    logic                w_m_tlast;

    // Round-robin search: the valid source closest to rr_ptr (wrapping upward) wins.
    always_comb begin
        w_hit     = 1'b0;
        w_winner  = 3'd0;
        w_best_d  = NUM_SRC;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (bus.src_tvalid[j] &&
                (((j + NUM_SRC - int'(r_rr_ptr)) % NUM_SRC) < w_best_d)) begin
                w_hit    = 1'b1;
                w_winner = 3'(j);
                w_best_d = (j + NUM_SRC - int'(r_rr_ptr)) % NUM_SRC;
            end
        end
        w_rr_next = 3'((int'(w_winner) + 1) % NUM_SRC);
    end

    // Select the granted source. Its ready is the only one raised, and only while collecting.
    always_comb begin
        w_sel_data  = 8'd0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_tready    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (3'(i) == r_grant_idx) begin
                w_sel_data  = bus.src_tdata[8*i +: 8];
                w_sel_valid = bus.src_tvalid[i];
                w_sel_last  = bus.src_tlast[i];
                w_tready[i] = (r_state == c_COLLECT) && (r_cnt < c_MAX);
            end
        end
    end

    assign w_accept   = |(w_tready & bus.src_tvalid);
    assign w_rd_last  = (r_rd == r_cnt - c_CNT_ONE);
    assign w_hdr_type = HDR_BASE[6:0] + {4'd0, r_grant_idx};

    // Output byte mux: header, then length, then the buffered data.
    always_comb begin
        w_m_tdata  = 8'd0;
        w_m_tvalid = 1'b0;
        w_m_tlast  = 1'b0;
        case (r_state)
            c_HDR: begin
                w_m_tvalid = 1'b1;
                w_m_tdata  = {r_eop, w_hdr_type};
            end
            c_LEN: begin
                w_m_tvalid = 1'b1;
                w_m_tdata  = 8'(r_cnt);
            end
            c_DATA: begin
                w_m_tvalid = 1'b1;
                w_m_tdata  = r_buf[r_rd[c_AW-1:0]];
                w_m_tlast  = w_rd_last;
            end
            default: begin
                w_m_tvalid = 1'b0;
            end
        endcase
    end

    // Main control: grant, collect with idle timeout, then frame out the record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_rr_ptr    <= 3'd0;
            r_grant_idx <= 3'd0;
            r_cnt       <= '0;
            r_rd        <= '0;
            r_timer     <= '0;
            r_eop       <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_hit) begin
                        r_grant_idx <= w_winner;
                        r_rr_ptr    <= w_rr_next;
                        r_timer     <= '0;
                        r_state     <= c_COLLECT;
                    end
                end
                c_COLLECT: begin
                    if (w_accept) begin
                        r_cnt   <= r_cnt + c_CNT_ONE;
                        r_timer <= '0;
                        if (w_sel_last) begin
                            r_eop   <= 1'b1;
                            r_state <= c_HDR;
                        end else if (r_cnt + c_CNT_ONE == c_MAX) begin
                            r_state <= c_HDR;
                        end
                    end else if (!w_sel_valid) begin
                        // The timer saturates, so an empty burst waits without wrapping.
                        if (r_timer == c_TMO_LAST) begin
                            if (r_cnt != '0) begin
                                r_state <= c_HDR;
                            end
                        end else begin
                            r_timer <= r_timer + c_TMR_ONE;
                        end
                    end
                end
                c_HDR: begin
                    if (bus.m_tready) begin
                        r_state <= c_LEN;
                    end
                end
                c_LEN: begin
                    if (bus.m_tready) begin
                        r_rd    <= '0;
                        r_state <= c_DATA;
                    end
                end
                c_DATA: begin
                    if (bus.m_tready) begin
                        if (w_rd_last) begin
                            r_cnt   <= '0;
                            r_eop   <= 1'b0;
                            r_state <= c_IDLE;
                        end else begin
                            r_rd <= r_rd + c_CNT_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Burst buffer. It holds no reset because cnt alone marks which entries are live.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_cnt[c_AW-1:0]] <= w_sel_data;
        end
    end

`ifdef UART_TX_SCHED_STATS_EN
    logic [15:0] r_rec_count;
    logic [15:0] r_byte_count;

    // Count delivered payload bytes and completed records. Both counters wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rec_count  <= 16'd0;
            r_byte_count <= 16'd0;
        end else if (r_state == c_DATA && bus.m_tready) begin
            r_byte_count <= r_byte_count + 16'd1;
            if (w_rd_last) begin
                r_rec_count <= r_rec_count + 16'd1;
            end
        end
    end

    assign rec_count  = r_rec_count;
    assign byte_count = r_byte_count;
`endif

    assign bus.src_tready = w_tready;
    assign bus.m_tdata    = w_m_tdata;
    assign bus.m_tvalid   = w_m_tvalid;
    assign bus.m_tlast    = w_m_tlast;
    assign busy           = (r_state != c_IDLE);
    assign grant_idx      = r_grant_idx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_scheduler
// Brief    : Self-checking bench for uart_tx_scheduler. Per-source byte queues
//            drive the producers. A record-level reference model predicts the
//            framed output stream and the grant order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

    localparam int         NS = 4;
    localparam int         MB = 16;
    localparam int         IT = 16;
    localparam logic [7:0] HB = 8'h08;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic [2:0] grant_idx;
`ifdef UART_TX_SCHED_STATS_EN
    logic [15:0] rec_count;
    logic [15:0] byte_count;
`endif

    uart_tx_scheduler_if #(.NUM_SRC(NS)) u_if ();

    uart_tx_scheduler #(
        .NUM_SRC      (NS),
        .MAX_BURST    (MB),
        .IDLE_TIMEOUT (IT),
        .HDR_BASE     (HB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (u_if),
        .busy       (busy),
        .grant_idx  (grant_idx)
`ifdef UART_TX_SCHED_STATS_EN
        ,
        .rec_count  (rec_count),
        .byte_count (byte_count)
`endif
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [8:0] sq [NS][$];   // bytes still to be offered, {tlast, data}
    logic [8:0] mq [NS][$];   // model copy of the same bytes
    logic [8:0] obs[$];
    logic [8:0] exp_q[$];
    logic [2:0] obs_g[$];
    logic [2:0] exp_g[$];
    int         mrr = 0;
    int         exp_rec = 0;
    int         exp_bytes = 0;
    int         cyc = 0;
    int         last_acc = 0;
    int         hdr_lat = 0;
    int         pops = 0;
    int         mode = 0;
    logic       prev_stall = 1'b0;
    logic       prev_mv = 1'b0;
    logic       rec_start = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NS; i++) if (sq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive();
        logic [8:0] b;
        for (int i = 0; i < NS; i++) begin
            b = (sq[i].size() > 0) ? sq[i][0] : 9'h000;
            u_if.src_tvalid[i]       = (sq[i].size() > 0);
            u_if.src_tdata[8*i +: 8] = b[7:0];
            u_if.src_tlast[i]        = b[8];
        end
    endtask

    task automatic push_byte(input int s, input logic [7:0] d, input logic last, input bit to_model);
        sq[s].push_back({last, d});
        if (to_model) mq[s].push_back({last, d});
    endtask

    // Reference: serve sources in round-robin order. Each grant takes bytes up to tlast or MB bytes.
    task automatic model();
        int         w;
        int         n;
        logic       eop;
        logic [8:0] b;
        logic [7:0] d[$];
        forever begin
            w = -1;
            for (int k = 0; k < NS; k++)
                if (w < 0 && mq[(mrr + k) % NS].size() > 0) w = (mrr + k) % NS;
            if (w < 0) break;
            d.delete();
            n = 0;
            eop = 1'b0;
            while (mq[w].size() > 0 && n < MB) begin
                b = mq[w].pop_front();
                d.push_back(b[7:0]);
                n++;
                if (b[8]) begin
                    eop = 1'b1;
                    break;
                end
            end
            exp_q.push_back({1'b0, eop, 7'(HB[6:0] + 7'(w))});
            exp_q.push_back({1'b0, 8'(n)});
            for (int j = 0; j < n; j++) exp_q.push_back({(j == n - 1), d[j]});
            exp_g.push_back(3'(w));
            mrr = (w + 1) % NS;
            exp_rec++;
            exp_bytes += n;
        end
    endtask

    // One clock: sample outputs at the falling edge, then update the inputs just after the rising edge.
    task automatic tick();
        logic [NS-1:0] hs;
        @(negedge clk);
        cyc++;
        hs = u_if.src_tvalid & u_if.src_tready;
        if (|hs) last_acc = cyc;
        if (u_if.m_tvalid && !prev_mv) hdr_lat = cyc - last_acc;
        prev_mv = u_if.m_tvalid;
        chk("tready_onehot", 32'($countones(u_if.src_tready) <= 1), 1);
        if (u_if.m_tvalid) chk("tready_during_output", 32'(u_if.src_tready), 0);
        if (prev_stall) chk("valid_held_in_stall", 32'(u_if.m_tvalid), 1);
        if (u_if.m_tvalid) begin
            if (obs.size() < exp_q.size())
                chk("out_byte", {23'd0, u_if.m_tlast, u_if.m_tdata}, 32'(exp_q[obs.size()]));
            else
                chk("unexpected_output", 32'(u_if.m_tvalid), 0);
        end
        prev_stall = u_if.m_tvalid && !u_if.m_tready;
        if (u_if.m_tvalid && u_if.m_tready) begin
            if (rec_start) obs_g.push_back(grant_idx);
            obs.push_back({u_if.m_tlast, u_if.m_tdata});
            rec_start = u_if.m_tlast;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (hs[i]) begin
                void'(sq[i].pop_front());
                pops++;
            end
        end
        case (mode)
            1:       u_if.m_tready = ~u_if.m_tready;
            2:       u_if.m_tready = 1'($urandom_range(0, 1));
            default: u_if.m_tready = 1'b1;
        endcase
        drive();
    endtask

    task automatic run(input string tag, input int budget);
        int k;
        k = 0;
        while (k < budget && !(all_empty() && busy === 1'b0)) begin
            tick();
            k++;
        end
        chk({tag, "_in_time"}, 32'(k < budget), 1);
        tick();
        chk({tag, "_byte_count"}, 32'(obs.size()), 32'(exp_q.size()));
        chk({tag, "_rec_count"}, 32'(obs_g.size()), 32'(exp_g.size()));
        for (int i = 0; i < obs_g.size() && i < exp_g.size(); i++)
            chk({tag, "_grant"}, 32'(obs_g[i]), 32'(exp_g[i]));
        chk({tag, "_busy_after"}, 32'(busy), 0);
`ifdef UART_TX_SCHED_STATS_EN
        chk({tag, "_stat_rec"}, 32'(rec_count), 32'(16'(exp_rec)));
        chk({tag, "_stat_bytes"}, 32'(byte_count), 32'(16'(exp_bytes)));
`endif
        obs.delete();
        exp_q.delete();
        obs_g.delete();
        exp_g.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NS; i++) begin
            sq[i].delete();
            mq[i].delete();
        end
        obs.delete();
        exp_q.delete();
        obs_g.delete();
        exp_g.delete();
        mrr = 0;
        exp_rec = 0;
        exp_bytes = 0;
        rec_start = 1'b1;
        prev_stall = 1'b0;
        drive();
        tick();
        tick();
        chk("rst_m_tvalid", 32'(u_if.m_tvalid), 0);
        chk("rst_m_tlast", 32'(u_if.m_tlast), 0);
        chk("rst_m_tdata", 32'(u_if.m_tdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant_idx", 32'(grant_idx), 0);
        chk("rst_src_tready", 32'(u_if.src_tready), 0);
`ifdef UART_TX_SCHED_STATS_EN
        chk("rst_rec_count", 32'(rec_count), 0);
        chk("rst_byte_count", 32'(byte_count), 0);
`endif
        rst_n = 1'b1;
    endtask

    initial begin
        int len;
        int npk;
        u_if.m_tready = 1'b1;
        mode = 0;
        drive();
        do_reset();

        // Two simultaneous single-byte requests from reset: src0 is served, then src2.
        push_byte(0, 8'h5A, 1'b1, 1'b1);
        push_byte(2, 8'hA5, 1'b1, 1'b1);
        model();
        drive();
        run("simul", 200);

        // Three bytes from src0 ending with tlast. The header must follow the closing byte by one cycle.
        push_byte(0, 8'hAA, 1'b0, 1'b1);
        push_byte(0, 8'hBB, 1'b0, 1'b1);
        push_byte(0, 8'hCC, 1'b1, 1'b1);
        model();
        drive();
        run("three", 200);
        chk("three_hdr_latency", 32'(hdr_lat), 1);

        // Twenty bytes from src1 split into a full record and a four-byte tail.
        for (int j = 0; j < 20; j++) push_byte(1, 8'(j), (j == 19), 1'b1);
        model();
        drive();
        run("split", 400);

        // Two bytes from src3 without tlast: the idle timeout closes the record.
        push_byte(3, 8'h31, 1'b0, 1'b1);
        push_byte(3, 8'h32, 1'b0, 1'b1);
        model();
        drive();
        run("timeout", 400);
        chk("timeout_hdr_latency", 32'(hdr_lat), 32'(IT + 1));

        // Back-pressure toggling every cycle, counted from a fresh reset.
        do_reset();
        mode = 1;
        for (int j = 0; j < 6; j++) push_byte(0, 8'($urandom), (j == 5), 1'b1);
        model();
        drive();
        run("toggle", 400);
        mode = 0;

        // Reset while five bytes are buffered. No record from that burst may appear.
        do_reset();
        pops = 0;
        for (int j = 0; j < 8; j++) push_byte(0, 8'(8'h40 + j), 1'b0, 1'b0);
        drive();
        for (int k = 0; k < 50 && pops < 5; k++) tick();
        chk("abort_pops", 32'(pops), 5);
        chk("abort_no_output", 32'(obs.size()), 0);
        do_reset();
        push_byte(0, 8'($urandom), 1'b1, 1'b1);
        model();
        drive();
        run("after_abort", 200);

        // Randomized mixes of packets on all sources under random back-pressure.
        for (int it = 0; it < 8; it++) begin
            mode = int'($urandom_range(0, 2));
            for (int s = 0; s < NS; s++) begin
                npk = int'($urandom_range(0, 2));
                for (int p = 0; p < npk; p++) begin
                    len = int'($urandom_range(1, 40));
                    for (int b = 0; b < len; b++) push_byte(s, 8'($urandom), (b == len - 1), 1'b1);
                end
            end
            model();
            drive();
            run("random", 4000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
